fifo_wr_arbiter: RTL

- Shares the single write port of the team's FIFO (write side of the dual-clock FIFO) between two byte-stream sources.
- Grants whole bursts of BURST_LEN words, alternating round-robin between the two sources.
- Grants a burst only when the FIFO has room for the entire burst, so bursts are never split and the FIFO never overflows.
- Sits in the write clock domain, between the two producers and the FIFO instance.

---
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for the shared FIFO write port
//
// Purpose:
//   Grants whole bursts of BURST_LEN words from one of two show-ahead byte
//   sources to the FIFO write port, alternating between sources. A burst is
//   granted only when the FIFO can take all of it, so bursts are never split.
//   Optional burst statistics are enabled with the macro ARB_STAT_EN.
//
// Ports:
//   sys_clk, sys_rst        write-side clock, asynchronous active-high reset
//   src0_req/src1_req       source holds at least BURST_LEN words
//   src0_data/src1_data     show-ahead source data
//   src0_rd/src1_rd         pop strobe, data consumed in the same cycle
//   fifo_usedw, fifo_full   FIFO write-side fill level and full flag
//   fifo_wr_req/_data       registered FIFO write strobe and data
//   grant                   one-hot owner of the active burst (00 when idle)
//   busy                    high while a burst or its trailing gap is active
//   stat_burst0/1           bursts granted per source (0 unless ARB_STAT_EN)

module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 9,
  parameter int DEPTH     = 512,
  parameter int BURST_LEN = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              src0_req,
  input  logic [DATA_W-1:0] src0_data,
  output logic              src0_rd,
  input  logic              src1_req,
  input  logic [DATA_W-1:0] src1_data,
  output logic              src1_rd,
  input  logic [ADDR_W-1:0] fifo_usedw,
  input  logic              fifo_full,
  output logic              fifo_wr_req,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [1:0]        grant,
  output logic              busy,
  output logic [15:0]       stat_burst0,
  output logic [15:0]       stat_burst1
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  // Two words of margin: one for the output register, one for usedw lag.
  localparam logic [ADDR_W:0]  SPACE_LIMIT = (ADDR_W+1)'(DEPTH - BURST_LEN - 2);
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic              r_last,  w_last_nxt;   // 1: source 1 won the last grant
  logic [CNT_W-1:0]  r_beat,  w_beat_nxt;
  logic              r_wr_req;
  logic [DATA_W-1:0] r_wr_data;

  logic w_space_ok;
  logic w_pop;
  logic w_start0;
  logic w_start1;

  assign w_space_ok = !fifo_full && ({1'b0, fifo_usedw} <= SPACE_LIMIT);
  assign w_pop      = (r_state == S_BURST) && !fifo_full;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_beat_nxt  = r_beat;
    w_start0    = 1'b0;
    w_start1    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_space_ok) begin
          // Source 0 wins when alone, or when both request and source 1 went last.
          if (src0_req && (!src1_req || r_last)) begin
            w_start0 = 1'b1;
          end else if (src1_req) begin
            w_start1 = 1'b1;
          end
        end
        if (w_start0 || w_start1) begin
          w_grant_nxt = {w_start1, w_start0};
          w_last_nxt  = w_start1;
          w_beat_nxt  = '0;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_pop) begin
          w_beat_nxt = r_beat + CNT_W'(1);
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 2'b00;
      r_last    <= 1'b1;
      r_beat    <= '0;
      r_wr_req  <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_beat   <= w_beat_nxt;
      r_wr_req <= w_pop;
      if (w_pop) begin
        r_wr_data <= r_grant[1] ? src1_data : src0_data;
      end
    end
  end

  assign src0_rd      = w_pop & r_grant[0];
  assign src1_rd      = w_pop & r_grant[1];
  assign fifo_wr_req  = r_wr_req;
  assign fifo_wr_data = r_wr_data;
  assign grant        = r_grant;
  assign busy         = (r_state != S_IDLE);

`ifdef ARB_STAT_EN
  logic [15:0] r_stat0;
  logic [15:0] r_stat1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_stat0 <= 16'h0000;
      r_stat1 <= 16'h0000;
    end else begin
      if (w_start0) r_stat0 <= r_stat0 + 16'd1;
      if (w_start1) r_stat1 <= r_stat1 + 16'd1;
    end
  end

  assign stat_burst0 = r_stat0;
  assign stat_burst1 = r_stat1;
`else
  assign stat_burst0 = 16'h0000;
  assign stat_burst1 = 16'h0000;
`endif

endmodule
